// File: rtl/order_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : order_pkg
//  Description : Shared types and constants for the order path. Holds the
//                order side encoding, the default stock-id / price widths
//                shared with the momentum signal generator, and the packed
//                order record carried through the order queue.
//  Revision    : 1.0  initial release
// ============================================================================
package order_pkg;

    // Default widths shared with the upstream signal generator.
    localparam int ID_W    = 2;
    localparam int PRICE_W = 6;

    // Order side encoding.
    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    // One queued order: {side, id, price}.
    typedef struct packed {
        logic               side;
        logic [ID_W-1:0]    id;
        logic [PRICE_W-1:0] price;
    } order_t;

    localparam int ORDER_W = 1 + ID_W + PRICE_W;

endpackage : order_pkg
`default_nettype wire

// File: rtl/order_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : order_fifo
//  Description : Synchronous FIFO of order_t records.
//                Ports: clk, rst (sync, active-high), push/din, pop/dout,
//                full, empty, count (0..FIFO_DEPTH).
//                dout is the head entry read directly from storage (no output
//                register) and is forced to zero while the FIFO is empty.
//                A push while full and a pop while empty are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module order_fifo
    import order_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  order_t           din,
    input  logic             pop,
    output order_t           dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(FIFO_DEPTH);

    order_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule : order_fifo
`default_nettype wire

// File: rtl/order_manager.sv
`default_nettype none
// ============================================================================
//  Module      : order_manager
//  Description : Turns buy/sell pulses from the momentum signal generator
//                into rate-limited, position-checked orders. Keeps a
//                long-only position and a cooldown timer per stock and queues
//                accepted orders for the transmit stage.
//  Ports       : clk, rst             - clock, sync active-high reset
//                buy_in, sell_in      - single-cycle signal pulses
//                stock_in, price_in   - registered once here to line up with
//                                       the pulses
//                halt                 - blocks new orders, queue still drains
//                order_valid/ready    - queue head handshake
//                order_side/id/price  - head order fields
//                query_id, query_pos  - combinational position read
//                fifo_count           - entries queued
//                drop_count/pulse     - rejected-event statistics
//  Revision    : 1.0  initial release
// ============================================================================
module order_manager
    import order_pkg::*;
#(
    parameter  int NUM_STOCKS = 4,
    parameter  int ID_W       = order_pkg::ID_W,
    parameter  int PRICE_W    = order_pkg::PRICE_W,
    parameter  int MAX_POS    = 3,
    parameter  int COOLDOWN   = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int POS_W      = $clog2(MAX_POS + 1),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buy_in,
    input  logic               sell_in,
    input  logic [ID_W-1:0]    stock_in,
    input  logic [PRICE_W-1:0] price_in,
    input  logic               halt,
    output logic               order_valid,
    input  logic               order_ready,
    output logic               order_side,
    output logic [ID_W-1:0]    order_id,
    output logic [PRICE_W-1:0] order_price,
    input  logic [ID_W-1:0]    query_id,
    output logic [POS_W-1:0]   query_pos,
    output logic [CNT_W-1:0]   fifo_count,
    output logic [7:0]         drop_count,
    output logic               drop_pulse
);

    localparam int               CD_W       = $clog2(COOLDOWN + 1);
    localparam logic [POS_W-1:0] c_max_pos  = POS_W'(MAX_POS);
    localparam logic [CD_W-1:0]  c_cooldown = CD_W'(COOLDOWN);

    // Stock/price arrive one cycle ahead of the pulse that refers to them.
    logic [ID_W-1:0]    r_stock;
    logic [PRICE_W-1:0] r_price;

    logic [POS_W-1:0]   r_pos [NUM_STOCKS];
    logic [CD_W-1:0]    r_cd  [NUM_STOCKS];
    logic [7:0]         r_drop_count;
    logic               r_drop_pulse;

    logic               w_buy;
    logic               w_sell;
    logic               w_full;
    logic               w_empty;
    logic               w_can_trade;
    logic               w_buy_ok;
    logic               w_sell_ok;
    logic               w_push;
    logic               w_pop;
    logic               w_reject;
    logic [POS_W-1:0]   w_pos_s;
    logic [CD_W-1:0]    w_cd_s;
    order_t             w_push_data;
    order_t             w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stock <= '0;
            r_price <= '0;
        end else begin
            r_stock <= stock_in;
            r_price <= price_in;
        end
    end

    // ------------------------------------------------------------------
    // Accept decision. Full uses the registered count, so a same-cycle
    // pop never makes room for a push.
    // ------------------------------------------------------------------
    assign w_buy       = buy_in & ~sell_in;
    assign w_sell      = sell_in & ~buy_in;
    assign w_pos_s     = r_pos[r_stock];
    assign w_cd_s      = r_cd[r_stock];
    assign w_can_trade = ~halt & (w_cd_s == '0) & ~w_full;
    assign w_buy_ok    = w_buy  & w_can_trade & (w_pos_s < c_max_pos);
    assign w_sell_ok   = w_sell & w_can_trade & (w_pos_s != '0);
    assign w_push      = w_buy_ok | w_sell_ok;
    // A conflict (both high) lands here because neither *_ok can be set.
    assign w_reject    = (buy_in | sell_in) & ~w_push;
    assign w_pop       = order_valid & order_ready;

    always_comb begin
        w_push_data       = '0;
        w_push_data.side  = w_sell_ok ? SIDE_SELL : SIDE_BUY;
        w_push_data.id    = r_stock;
        w_push_data.price = r_price;
    end

    // ------------------------------------------------------------------
    // Position and cooldown per stock. A load on accept wins over the
    // free-running decrement; halt does not stop the timers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                r_pos[i] <= '0;
                r_cd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                if (w_push && (r_stock == ID_W'(i))) begin
                    r_cd[i]  <= c_cooldown;
                    r_pos[i] <= w_buy_ok ? r_pos[i] + POS_W'(1)
                                         : r_pos[i] - POS_W'(1);
                end else if (r_cd[i] != '0) begin
                    r_cd[i] <= r_cd[i] - CD_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_reject;
            if (w_reject && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    order_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_push_data),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    assign order_valid = ~w_empty;
    assign order_side  = w_head.side;
    assign order_id    = w_head.id;
    assign order_price = w_head.price;
    assign query_pos   = r_pos[query_id];
    assign drop_count  = r_drop_count;
    assign drop_pulse  = r_drop_pulse;

endmodule : order_manager
`default_nettype wire

// File: doc/order_manager.md
Name: order_manager

Overview:
- Downstream stage of the per-stock momentum signal generator. Turns single-cycle buy/sell pulses into rate-limited, position-checked orders.
- Keeps a long-only position and a cooldown timer per stock. Queues accepted orders in a small FIFO that the order-output/transmit stage drains over a valid/ready handshake.

Parameters:
- NUM_STOCKS, 4, number of tracked instruments
- ID_W, 2, stock id width (log2 NUM_STOCKS)
- PRICE_W, 6, price width
- MAX_POS, 3, maximum units held per stock
- COOLDOWN, 4, cycles a stock is blocked after an accepted order
- FIFO_DEPTH, 4, order queue depth (power of two)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- buy_in  in  1  buy pulse from signal generator
- sell_in  in  1  sell pulse from signal generator
- stock_in  in  ID_W  stock id; top level aligns it to the signal pulses with a one-cycle register
- price_in  in  PRICE_W  price; aligned the same way as stock_in
- halt  in  1  high blocks new orders; the queue still drains
- order_valid  out  1  queue head valid
- order_ready  in  1  consumer accepts head
- order_side  out  1  0=BUY, 1=SELL
- order_id  out  ID_W  stock of head order
- order_price  out  PRICE_W  price of head order
- query_id  in  ID_W  position query select
- query_pos  out  2  pos[query_id], combinational read; width = clog2(MAX_POS+1)
- fifo_count  out  3  entries queued, 0..FIFO_DEPTH
- drop_count  out  8  saturating count of rejected events
- drop_pulse  out  1  one-cycle pulse on any rejection

Behaviour:
- Reset values:
  - all pos[i] = 0 and cd[i] = 0
  - FIFO empty; order_valid = 0; order_side, order_id, order_price = 0
  - fifo_count = 0; drop_count = 0; drop_pulse = 0
- Events are sampled at each rising clk edge.
  - BUY event: buy_in & ~sell_in.
  - SELL event: sell_in & ~buy_in.
  - Conflict: both high. Conflict is rejected.
- BUY is accepted iff all hold: ~halt, cd[s]==0, pos[s]<MAX_POS, fifo_count<FIFO_DEPTH.
  - On accept: push {0,s,price}; pos[s]+=1; cd[s]<=COOLDOWN.
- SELL is accepted iff all hold: ~halt, cd[s]==0, pos[s]>0, fifo_count<FIFO_DEPTH.
  - On accept: push {1,s,price}; pos[s]-=1; cd[s]<=COOLDOWN.
- A rejected event (including a conflict) has these effects:
  - no state change to pos or cd;
  - drop_pulse=1 for the next cycle only;
  - drop_count+=1, saturating at 255.
- No event (both inputs low): drop_pulse=0 and nothing is counted.
- Cooldown:
  - every cd[i]>0 decrements by 1 each cycle, independent of events;
  - a load on accept overrides the decrement for that stock;
  - minimum spacing between accepted orders on one stock is COOLDOWN+1 edges;
  - other stocks are unaffected.
- Full check uses the registered count before any same-cycle pop. A push is refused when full even if order_ready pops in the same cycle.
- Pop occurs when order_valid & order_ready. Simultaneous push+pop on a non-full queue leaves fifo_count unchanged.
- Latency:
  - an event accepted at edge N into an empty queue gives order_valid=1 after edge N;
  - order fields are driven directly from the head entry; no extra register stage.
- Ordering: strict FIFO across all stocks.
- order_side/id/price are valid only while order_valid=1. They must hold stable while order_valid & ~order_ready.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is a separate counter, 0..FIFO_DEPTH.
- halt does not flush the queue and does not freeze cooldown.
- rst mid-operation: the queue is discarded and positions are cleared on the same edge. order_valid is 0 the following cycle.

Decomposition:
- Package order_pkg holds:
  - SIDE_BUY=1'b0 and SIDE_SELL=1'b1;
  - order_t = {side, id, price}, width 1+ID_W+PRICE_W;
  - default ID_W and PRICE_W constants shared with the signal generator.
- One sub-module: order_fifo. It is a synchronous FIFO carrying order_t, with push/pop, full/empty and count, parameterised by FIFO_DEPTH.
- Position and cooldown arrays plus accept logic stay in order_manager.

Test Plan:
- Buy pulse, stock 1, price 20, order_ready=1 → order_valid for exactly one cycle with side=0, id=1, price=20; query_pos(1)=1; drop_count=0.
- Buy on stock 2 at cycle 0, buy on stock 2 again at cycle 2 → second is rejected (drop_pulse, drop_count=1). A third buy at cycle 5 (COOLDOWN+1) is accepted; query_pos(2)=2.
- Sell on stock 0 with pos=0 → rejected, drop_count=1, no order. Buy then sell after cooldown → two orders in order BUY, SELL; final pos=0.
- order_ready=0; accepted buys on stocks 0,1,2,3 and then on stock 0 after cooldown → fifo_count=4, fifth rejected. Raise order_ready → pops in id order 0,1,2,3. Head fields stay stable while stalled.
- buy_in=sell_in=1 → rejected, drop_pulse=1, positions unchanged. With halt=1 and 3 queued, a valid buy is rejected while the queue drains to 0.
- With 2 orders queued and pos[3]=2, assert rst for one cycle → order_valid=0, fifo_count=0, query_pos(3)=0, drop_count=0 next cycle.
